// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC interrupt scheduler.
//   state_t        - scheduler FSM states (IDLE, PEND, WAIT2)
//   NUM_IR, LVL_W  - request line count and level encoding width
//   EOI_NS..SET_PRI - OCW2 {R,SL,EOI} command codes
//   prio_rank()    - rank of a level under the current rotation (0 = highest)
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int LVL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    localparam logic [2:0] EOI_NS  = 3'b001;
    localparam logic [2:0] EOI_SP  = 3'b011;
    localparam logic [2:0] ROT_NS  = 3'b101;
    localparam logic [2:0] ROT_SP  = 3'b111;
    localparam logic [2:0] SET_PRI = 3'b110;

    // The level just after 'lowest' is rank 0; 3-bit wrap does the mod 8.
    function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                   input logic [LVL_W-1:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// pic_rot_prio_enc: rotating find-first over an 8-bit request vector.
// Ports:
//   vec    in  8  candidate bits
//   lowest in  3  lowest-priority level; search starts at lowest+1 and wraps
//   valid  out 1  any bit of vec set
//   lvl    out 3  highest-priority set level (0 when !valid)
module pic_rot_prio_enc
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec,
    input  logic [LVL_W-1:0]  lowest,
    output logic              valid,
    output logic [LVL_W-1:0]  lvl
);

    logic [LVL_W-1:0] idx;

    // Scan from the lowest priority up to the highest so the last hit wins.
    always_comb begin
        valid = 1'b0;
        lvl   = '0;
        idx   = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            idx = lowest + LVL_W'(i + 1);
            if (vec[idx]) begin
                valid = 1'b1;
                lvl   = idx;
            end
        end
    end

endmodule

// File: rtl/pic_irq_scheduler.sv
// pic_irq_scheduler: IRR/ISR bookkeeping, nested priority resolution and the
// two-pulse INTA acknowledge sequence of the PIC.
// Optional feature macro: PIC_AUTO_ROTATE_EN (rotate priority on AEOI).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ir[7:0]           synchronised request lines
//   ltim              1 = level-triggered, 0 = edge-triggered
//   imr[7:0]          mask, 1 = masked
//   aeoi, aeoi_rotate automatic EOI, rotate-on-AEOI
//   vec_base[4:0]     vector T7..T3
//   inta_stb          one strobe per INTA pulse
//   eoi_stb, eoi_cmd, eoi_lvl  OCW2 command
//   int_req           INT to the CPU
//   irr_q, isr_q      request / in-service registers
//   vector, vector_vld, spurious  acknowledge result (one-cycle pulses)
//   state_dbg         current FSM state
//
// Acknowledge handshake: int_req is raised in PEND and held until the first
// inta_stb, which commits the level (ACK1); the second inta_stb in WAIT2
// returns the vector with a one-cycle vector_vld. inta_stb outside PEND/WAIT2
// is ignored; there is no backpressure.
module pic_irq_scheduler
    import pic_pkg::*;
#(
    parameter int RESET_LOWEST = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] ir,
    input  logic              ltim,
    input  logic [NUM_IR-1:0] imr,
    input  logic              aeoi,
    input  logic              aeoi_rotate,
    input  logic [4:0]        vec_base,
    input  logic              inta_stb,
    input  logic              eoi_stb,
    input  logic [2:0]        eoi_cmd,
    input  logic [LVL_W-1:0]  eoi_lvl,
    output logic              int_req,
    output logic [NUM_IR-1:0] irr_q,
    output logic [NUM_IR-1:0] isr_q,
    output logic [7:0]        vector,
    output logic              vector_vld,
    output logic              spurious,
    output state_t            state_dbg
);

    state_t            state;
    logic [NUM_IR-1:0] ir_d;
    logic [LVL_W-1:0]  lowest;
    logic [LVL_W-1:0]  ack_lvl;
    logic              spurious_flag;

    logic [NUM_IR-1:0] pend_vec;
    logic              req_valid, srv_valid;
    logic [LVL_W-1:0]  req_lvl, srv_lvl;
    logic              eligible;
    logic              ack1_hit, ack2;
    logic [NUM_IR-1:0] irr_nx, isr_nx;
    logic [LVL_W-1:0]  lowest_nx;

    assign pend_vec  = irr_q & ~imr;
    assign state_dbg = state;

    pic_rot_prio_enc u_req_enc (
        .vec    (pend_vec),
        .lowest (lowest),
        .valid  (req_valid),
        .lvl    (req_lvl)
    );

    pic_rot_prio_enc u_srv_enc (
        .vec    (isr_q),
        .lowest (lowest),
        .valid  (srv_valid),
        .lvl    (srv_lvl)
    );

    // Fully nested: a request must strictly outrank everything in service.
    assign eligible = req_valid &&
                      (!srv_valid || (prio_rank(req_lvl, lowest) < prio_rank(srv_lvl, lowest)));

    assign ack1_hit = (state == PEND) && inta_stb && eligible;
    assign ack2     = (state == WAIT2) && inta_stb;

    // IRR: the ACK1 clear is applied last so it beats a same-cycle new edge.
    always_comb begin
        irr_nx = ltim ? ir : (irr_q | (ir & ~ir_d));
        if (ack1_hit) irr_nx[req_lvl] = 1'b0;
    end

    // ISR and rotation: EOI clears first, then the ACK1 set so set wins.
    always_comb begin
        isr_nx    = isr_q;
        lowest_nx = lowest;
        if (eoi_stb) begin
            case (eoi_cmd)
                EOI_NS: if (srv_valid) isr_nx[srv_lvl] = 1'b0;
                ROT_NS: if (srv_valid) begin
                    isr_nx[srv_lvl] = 1'b0;
                    lowest_nx       = srv_lvl;
                end
                EOI_SP: isr_nx[eoi_lvl] = 1'b0;
                ROT_SP: begin
                    isr_nx[eoi_lvl] = 1'b0;
                    lowest_nx       = eoi_lvl;
                end
                SET_PRI: lowest_nx = eoi_lvl;
                default: ;
            endcase
        end
        if (ack1_hit) isr_nx[req_lvl] = 1'b1;
        if (ack2 && aeoi && !spurious_flag) isr_nx[ack_lvl] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
        if (ack2 && aeoi && aeoi_rotate && !spurious_flag) lowest_nx = ack_lvl;
`endif
    end

`ifndef PIC_AUTO_ROTATE_EN
    logic unused_aeoi_rotate;
    assign unused_aeoi_rotate = aeoi_rotate;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ir_d          <= '0;
            irr_q         <= '0;
            isr_q         <= '0;
            lowest        <= LVL_W'(RESET_LOWEST);
            ack_lvl       <= '0;
            spurious_flag <= 1'b0;
            int_req       <= 1'b0;
            vector        <= '0;
            vector_vld    <= 1'b0;
            spurious      <= 1'b0;
        end else begin
            ir_d       <= ir;
            irr_q      <= irr_nx;
            isr_q      <= isr_nx;
            lowest     <= lowest_nx;
            vector_vld <= 1'b0;
            spurious   <= 1'b0;
            case (state)
                IDLE: begin
                    int_req <= 1'b0;
                    if (eligible) begin
                        state   <= PEND;
                        int_req <= 1'b1;
                    end
                end
                PEND: begin
                    // int_req holds even if the request vanishes; the ack then goes spurious.
                    int_req <= 1'b1;
                    if (inta_stb) begin
                        state         <= WAIT2;
                        int_req       <= 1'b0;
                        ack_lvl       <= eligible ? req_lvl : 3'd7;
                        spurious_flag <= !eligible;
                    end
                end
                WAIT2: begin
                    int_req <= 1'b0;
                    if (inta_stb) begin
                        vector     <= {vec_base, ack_lvl};
                        vector_vld <= 1'b1;
                        spurious   <= spurious_flag;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_irq_scheduler.sv
// Testbench for pic_irq_scheduler: table of per-cycle vectors plus directed
// AEOI and reset-mid-handshake sequences. Vectors are checked through an
// expected queue drained by a monitor on vector_vld.
module tb_pic_irq_scheduler;
    import pic_pkg::*;

`ifdef PIC_AUTO_ROTATE_EN
    localparam bit AUTO_ROT = 1'b1;
`else
    localparam bit AUTO_ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic       ltim;
    logic [7:0] imr;
    logic       aeoi;
    logic       aeoi_rotate;
    logic [4:0] vec_base;
    logic       inta_stb;
    logic       eoi_stb;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_lvl;
    logic       int_req;
    logic [7:0] irr_q;
    logic [7:0] isr_q;
    logic [7:0] vector;
    logic       vector_vld;
    logic       spurious;
    state_t     state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] ir;
        logic       ltim;
        logic       inta;
        logic       eoi;
        logic [2:0] cmd;
        logic [2:0] lvl;
        logic       x_int;
        logic [7:0] x_irr;
        logic [7:0] x_isr;
        logic       x_vld;
        logic [7:0] x_vec;
        logic       x_spur;
    } vec_t;

    vec_t tbl[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pic_irq_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .ir          (ir),
        .ltim        (ltim),
        .imr         (imr),
        .aeoi        (aeoi),
        .aeoi_rotate (aeoi_rotate),
        .vec_base    (vec_base),
        .inta_stb    (inta_stb),
        .eoi_stb     (eoi_stb),
        .eoi_cmd     (eoi_cmd),
        .eoi_lvl     (eoi_lvl),
        .int_req     (int_req),
        .irr_q       (irr_q),
        .isr_q       (isr_q),
        .vector      (vector),
        .vector_vld  (vector_vld),
        .spurious    (spurious),
        .state_dbg   (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic x_int, input logic [7:0] x_irr,
                              input logic [7:0] x_isr, input logic x_vld, input logic x_spur);
        chk({tag, ".int_req"},    8'(int_req),    8'(x_int));
        chk({tag, ".irr_q"},      irr_q,          x_irr);
        chk({tag, ".isr_q"},      isr_q,          x_isr);
        chk({tag, ".vector_vld"}, 8'(vector_vld), 8'(x_vld));
        chk({tag, ".spurious"},   8'(spurious),   8'(x_spur));
    endtask

    // Scoreboard: every vector_vld pulse must match the oldest expected vector.
    always @(negedge clk) begin
        if (vector_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL vector_unexpected: got %h expected none", vector);
            end else begin
                chk("vector", vector, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; applies inputs for one full clock cycle.
    task automatic drive(input logic [7:0] ir_v, input logic ltim_v, input logic inta_v,
                         input logic eoi_v, input logic [2:0] cmd_v, input logic [2:0] lvl_v);
        ir       = ir_v;
        ltim     = ltim_v;
        inta_stb = inta_v;
        eoi_stb  = eoi_v;
        eoi_cmd  = cmd_v;
        eoi_lvl  = lvl_v;
        @(negedge clk);
    endtask

    function automatic void add(input logic [7:0] r_ir, input logic r_ltim, input logic r_inta,
                                input logic r_eoi, input logic [2:0] r_cmd, input logic [2:0] r_lvl,
                                input logic x_int, input logic [7:0] x_irr, input logic [7:0] x_isr,
                                input logic x_vld, input logic [7:0] x_vec, input logic x_spur);
        vec_t v;
        v.ir = r_ir;   v.ltim = r_ltim; v.inta = r_inta; v.eoi = r_eoi;
        v.cmd = r_cmd; v.lvl = r_lvl;   v.x_int = x_int; v.x_irr = x_irr;
        v.x_isr = x_isr; v.x_vld = x_vld; v.x_vec = x_vec; v.x_spur = x_spur;
        tbl.push_back(v);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Row columns: ir ltim inta eoi cmd lvl | int irr isr vld vec spur
        // Edge request on IR3, vector 0x43
        add(8'h08,0,0,0,3'b000,3'd0, 0,8'h08,8'h00,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 1,8'h08,8'h00,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h08,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h08,1,8'h43,0);
        // Nesting: IR5 blocked by ISR3, IR1 preempts
        add(8'h20,0,0,0,3'b000,3'd0, 0,8'h20,8'h08,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 0,8'h20,8'h08,0,8'h00,0);
        add(8'h02,0,0,0,3'b000,3'd0, 0,8'h22,8'h08,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 1,8'h22,8'h08,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h20,8'h0A,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h20,8'h0A,1,8'h41,0);
        add(8'h00,0,0,1,3'b001,3'd0, 0,8'h20,8'h08,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 0,8'h20,8'h08,0,8'h00,0);
        add(8'h00,0,0,1,3'b011,3'd3, 0,8'h20,8'h00,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 1,8'h20,8'h00,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h20,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h20,1,8'h45,0);
        add(8'h00,0,0,1,3'b011,3'd5, 0,8'h00,8'h00,0,8'h00,0);
        // Rotation: lowest=4 picks IR5 over IR0, rotate-specific 5 then IR0 wins
        add(8'h21,0,0,1,3'b110,3'd4, 0,8'h21,8'h00,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 1,8'h21,8'h00,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h01,8'h20,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h01,8'h20,1,8'h45,0);
        add(8'h00,0,0,1,3'b111,3'd5, 0,8'h01,8'h00,0,8'h00,0);
        add(8'h00,0,0,0,3'b000,3'd0, 1,8'h01,8'h00,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h01,0,8'h00,0);
        add(8'h00,0,1,0,3'b000,3'd0, 0,8'h00,8'h01,1,8'h40,0);
        add(8'h00,0,0,1,3'b001,3'd0, 0,8'h00,8'h00,0,8'h00,0);
        add(8'h00,0,0,1,3'b110,3'd7, 0,8'h00,8'h00,0,8'h00,0);
        // Spurious: level IR2 drops while pending
        add(8'h04,1,0,0,3'b000,3'd0, 0,8'h04,8'h00,0,8'h00,0);
        add(8'h04,1,0,0,3'b000,3'd0, 1,8'h04,8'h00,0,8'h00,0);
        add(8'h00,1,0,0,3'b000,3'd0, 1,8'h00,8'h00,0,8'h00,0);
        add(8'h00,1,1,0,3'b000,3'd0, 0,8'h00,8'h00,0,8'h00,0);
        add(8'h00,1,1,0,3'b000,3'd0, 0,8'h00,8'h00,1,8'h47,1);
        add(8'h00,0,0,0,3'b000,3'd0, 0,8'h00,8'h00,0,8'h00,0);

        // ---- reset ----
        reset = 1'b1; ir = '0; ltim = 1'b0; imr = '0; aeoi = 1'b0; aeoi_rotate = 1'b0;
        vec_base = 5'h08; inta_stb = 1'b0; eoi_stb = 1'b0; eoi_cmd = '0; eoi_lvl = '0;
        repeat (2) @(negedge clk);
        check_outs("reset", 0, 8'h00, 8'h00, 0, 0);
        chk("reset.vector", vector, 8'h00);
        chk("reset.state", 8'(state_dbg), 8'(IDLE));
        reset = 1'b0;

        // ---- table ----
        foreach (tbl[i]) begin
            if (tbl[i].x_vld) exp_q.push_back(tbl[i].x_vec);
            drive(tbl[i].ir, tbl[i].ltim, tbl[i].inta, tbl[i].eoi, tbl[i].cmd, tbl[i].lvl);
            check_outs($sformatf("row%0d", i), tbl[i].x_int, tbl[i].x_irr, tbl[i].x_isr,
                       tbl[i].x_vld, tbl[i].x_spur);
        end

        // ---- AEOI on IR6; with auto-rotate lowest becomes 6, so IR7 beats IR0 ----
        aeoi = 1'b1; aeoi_rotate = 1'b1;
        drive(8'h40, 0, 0, 0, 3'b000, 3'd0); check_outs("aeoi1", 0, 8'h40, 8'h00, 0, 0);
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0); check_outs("aeoi2", 1, 8'h40, 8'h00, 0, 0);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0); check_outs("aeoi3", 0, 8'h00, 8'h40, 0, 0);
        exp_q.push_back(8'h46);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0); check_outs("aeoi4", 0, 8'h00, 8'h00, 1, 0);
        drive(8'h81, 0, 0, 0, 3'b000, 3'd0); check_outs("aeoi5", 0, 8'h81, 8'h00, 0, 0);
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0); check_outs("aeoi6", 1, 8'h81, 8'h00, 0, 0);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0);
        check_outs("aeoi7", 0, AUTO_ROT ? 8'h01 : 8'h80, AUTO_ROT ? 8'h80 : 8'h01, 0, 0);
        exp_q.push_back(AUTO_ROT ? 8'h47 : 8'h40);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0);
        check_outs("aeoi8", 0, AUTO_ROT ? 8'h01 : 8'h80, 8'h00, 1, 0);
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0);
        check_outs("aeoi9", 1, AUTO_ROT ? 8'h01 : 8'h80, 8'h00, 0, 0);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0);
        check_outs("aeoi10", 0, 8'h00, AUTO_ROT ? 8'h01 : 8'h80, 0, 0);
        exp_q.push_back(AUTO_ROT ? 8'h40 : 8'h47);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0); check_outs("aeoi11", 0, 8'h00, 8'h00, 1, 0);
        aeoi = 1'b0; aeoi_rotate = 1'b0;

        // ---- reset while in WAIT2: the second INTA must yield nothing ----
        drive(8'h10, 0, 0, 0, 3'b000, 3'd0); check_outs("rst1", 0, 8'h10, 8'h00, 0, 0);
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0); check_outs("rst2", 1, 8'h10, 8'h00, 0, 0);
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0); check_outs("rst3", 0, 8'h00, 8'h10, 0, 0);
        chk("rst3.state", 8'(state_dbg), 8'(WAIT2));
        reset = 1'b1;
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0);
        check_outs("rst4", 0, 8'h00, 8'h00, 0, 0);
        chk("rst4.vector", vector, 8'h00);
        chk("rst4.state", 8'(state_dbg), 8'(IDLE));
        reset = 1'b0;
        drive(8'h00, 0, 1, 0, 3'b000, 3'd0); check_outs("rst5", 0, 8'h00, 8'h00, 0, 0);
        chk("rst5.state", 8'(state_dbg), 8'(IDLE));
        drive(8'h00, 0, 0, 0, 3'b000, 3'd0); check_outs("rst6", 0, 8'h00, 8'h00, 0, 0);

        chk("exp_q_left", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
